lsu_stage: RTL and testbench

Parametrised memory-access (MEM) pipeline stage for the RISC-V core, sitting between execute and writeback. It accepts one load or store per accepted instruction and drives a request/acknowledge data-memory bus with byte enables, so it tolerates variable memory latency. It formats load data (byte, half, word, and double for XLEN=64) into the load-memory-data register with sign or zero extension. It also produces the branch-resolved next PC, stalls the pipeline while an access is outstanding, and aborts accesses that time out.

---
 rtl/lsu_stage.sv | 208 ++++++++++++++++++++
 tb/tb_lsu_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/lsu_stage.sv
// lsu_stage - memory-access pipeline stage between execute and writeback.
//
// Issues one load or store per accepted instruction onto a req/ack data bus
// and formats load data into lmd. It also resolves the next PC, stalls the
// upstream pipeline while an access is in flight, and aborts accesses that
// wait TIMEOUT cycles without an acknowledge.
//
// Handshake: mem_req rises the cycle after a start and holds every bus
// output stable until mem_ack is sampled high on a rising edge. That edge
// completes the access and drops mem_req.
//
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   ex_valid/ex_re/ex_we         instruction present, load, store
//   ex_funct3                    access size and sign
//   ex_addr, ex_wdata            byte address (also branch target), store data
//   ex_npc, ex_cond              sequential next PC, branch taken
//   mem_req/we/addr/be/wdata     registered bus request
//   mem_rdata, mem_ack           bus response
//   lmd                          formatted load result
//   condpc                       resolved next PC (combinational)
//   stall                        hold upstream (combinational)
//   fault, bus_err               one-cycle pulses: bad access, timeout abort
//   dbg_state                    FSM state (1 = BUSY)
module lsu_stage #(
  parameter int XLEN    = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic              ex_re,
  input  logic              ex_we,
  input  logic [2:0]        ex_funct3,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [XLEN-1:0]   ex_wdata,
  input  logic [ADDR_W-1:0] ex_npc,
  input  logic              ex_cond,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata,
  input  logic              mem_ack,
  output logic [XLEN-1:0]   lmd,
  output logic [ADDR_W-1:0] condpc,
  output logic              stall,
  output logic              fault,
  output logic              bus_err,
  output logic              dbg_state
);
  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  state_t state, state_nx;

  logic [OFF_W-1:0] off;
  logic [1:0]       size;
  logic             illegal, misaligned, req_any;
  logic             start, reject, ack_done, abort, tmo_hit;
  logic [NB-1:0]    be_nx;
  logic [XLEN-1:0]  wdata_nx, lane, lmd_nx;
  // Attributes of the in-flight access, needed to format the returned data.
  logic             op_re;
  logic [2:0]       op_f3;
  logic [OFF_W-1:0] op_off;
  logic [CNT_W-1:0] wait_cnt;

  assign off       = ex_addr[OFF_W-1:0];
  assign size      = ex_funct3[1:0];
  assign req_any   = ex_valid & (ex_re | ex_we);
  assign condpc    = ex_cond ? ex_addr : ex_npc;
  assign dbg_state = (state == BUSY);
  // Abort fires in the TIMEOUT-th BUSY cycle, so mem_req is high TIMEOUT cycles.
  assign tmo_hit   = (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign stall     = start | ((state == BUSY) & ~mem_ack);

  always_comb begin
    illegal    = (ex_re & ex_we) | (ex_funct3 == 3'b111);
    misaligned = 1'b0;
    if (XLEN == 32 && (ex_funct3 == 3'b011 || ex_funct3 == 3'b110))
      illegal = 1'b1;
    case (size)
      2'd1:    misaligned = ex_addr[0];
      2'd2:    misaligned = |ex_addr[1:0];
      2'd3:    misaligned = |ex_addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  // Next-state and control strobes.
  always_comb begin
    state_nx = state;
    start    = 1'b0;
    reject   = 1'b0;
    ack_done = 1'b0;
    abort    = 1'b0;
    case (state)
      IDLE: begin
        if (req_any) begin
          if (illegal | misaligned) begin
            reject = 1'b1;
          end else begin
            start    = 1'b1;
            state_nx = BUSY;
          end
        end
      end
      BUSY: begin
        // An ack on the timeout cycle still completes the access normally.
        if (mem_ack) begin
          ack_done = 1'b1;
          state_nx = IDLE;
        end else if (tmo_hit) begin
          abort    = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Store lanes: enables shifted to the byte offset, data replicated so the
  // addressed lane always carries the right-aligned store value.
  always_comb begin
    be_nx    = '0;
    wdata_nx = '0;
    case (size)
      2'd0: begin
        be_nx = NB'(1) << off;
        for (int i = 0; i < NB; i++) wdata_nx[i*8 +: 8] = ex_wdata[7:0];
      end
      2'd1: begin
        be_nx = NB'(3) << off;
        for (int i = 0; i < NB / 2; i++) wdata_nx[i*16 +: 16] = ex_wdata[15:0];
      end
      2'd2: begin
        be_nx = NB'(15) << off;
        for (int i = 0; i < NB / 4; i++) wdata_nx[i*32 +: 32] = ex_wdata[31:0];
      end
      default: begin
        be_nx    = '1;
        wdata_nx = ex_wdata;
      end
    endcase
  end

  // Load formatting: bring the addressed lane down to bit 0, then extend.
  always_comb begin
    lane   = mem_rdata >> {op_off, 3'b000};
    lmd_nx = lane;
    case (op_f3)
      3'b000:  lmd_nx = XLEN'($signed(lane[7:0]));
      3'b001:  lmd_nx = XLEN'($signed(lane[15:0]));
      3'b010:  lmd_nx = XLEN'($signed(lane[31:0]));
      3'b100:  lmd_nx = XLEN'(lane[7:0]);
      3'b101:  lmd_nx = XLEN'(lane[15:0]);
      3'b110:  lmd_nx = XLEN'(lane[31:0]);
      default: lmd_nx = lane;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      lmd       <= '1;
      fault     <= 1'b0;
      bus_err   <= 1'b0;
      op_re     <= 1'b0;
      op_f3     <= '0;
      op_off    <= '0;
      wait_cnt  <= '0;
    end else begin
      state   <= state_nx;
      fault   <= reject;
      bus_err <= abort;
      if (start) begin
        mem_req   <= 1'b1;
        mem_we    <= ex_we;
        mem_addr  <= {ex_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        mem_be    <= be_nx;
        mem_wdata <= wdata_nx;
        op_re     <= ex_re;
        op_f3     <= ex_funct3;
        op_off    <= off;
        wait_cnt  <= '0;
      end else if (ack_done || abort) begin
        mem_req  <= 1'b0;
        mem_we   <= 1'b0;
        mem_be   <= '0;
        wait_cnt <= '0;
        if (ack_done && op_re) lmd <= lmd_nx;
      end else if (state == BUSY) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lsu_stage.sv
// Testbench for lsu_stage (XLEN=32, TIMEOUT=4): directed cases followed by
// randomized accesses checked against a byte-level reference model.
module tb_lsu_stage;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_re, ex_we, ex_cond;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata, ex_npc;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, lmd, condpc;
  logic [3:0]  mem_be;
  logic        stall, fault, bus_err, dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] lmd_model;

  lsu_stage #(.XLEN(32), .ADDR_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_re(ex_re), .ex_we(ex_we), .ex_funct3(ex_funct3),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_npc(ex_npc), .ex_cond(ex_cond),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .lmd(lmd), .condpc(condpc), .stall(stall), .fault(fault),
    .bus_err(bus_err), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: sizes in bytes, lanes by address modulo 4.
  function automatic logic [31:0] size_mask(input int nbytes);
    return (nbytes >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rd);
    int nbytes;
    logic [31:0] mask, v;
    nbytes = 1 << f3[1:0];
    mask   = size_mask(nbytes);
    v      = (rd >> (8 * (addr % 4))) & mask;
    if (!f3[2] && nbytes < 4 && v[8*nbytes-1]) v = v | ~mask;
    return v;
  endfunction

  // Driver: one instruction from presentation to completion.
  task automatic do_access(input bit re, input bit we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int waits, input logic [31:0] rd);
    int nbytes, k;
    bit bad, cond, done;
    logic [31:0] npc, mask, exp_wd, dummy;
    logic [3:0] exp_be;
    nbytes = 1 << f3[1:0];
    bad = (re && we) || f3 == 3'd7 || f3 == 3'd3 || f3 == 3'd6 || (addr % nbytes) != 0;
    mask = size_mask(nbytes);
    exp_be = 4'(((1 << nbytes) - 1) << (addr % 4));
    exp_wd = '0;
    for (int i = 0; i < 4; i += nbytes) exp_wd = exp_wd | ((wd & mask) << (8 * i));
    cond = 1'($urandom_range(0, 1));
    npc = $urandom;

    @(negedge clk);
    ex_valid = 1'b1; ex_re = re; ex_we = we; ex_funct3 = f3;
    ex_addr = addr; ex_wdata = wd; ex_npc = npc; ex_cond = cond;
    mem_ack = 1'b0; mem_rdata = $urandom;
    #1;
    check("condpc", condpc, cond ? addr : npc);

    if (!re && !we) begin
      check("pass_stall", stall, 1'b0);
      @(negedge clk); ex_valid = 1'b0; #1;
      check("pass_req", mem_req, 1'b0);
      check("pass_fault", fault, 1'b0);
      return;
    end

    if (bad) begin
      check("bad_stall", stall, 1'b0);
      @(negedge clk); ex_valid = 1'b0; #1;
      check("fault_pulse", fault, 1'b1);
      check("bad_req", mem_req, 1'b0);
      check("bad_lmd", lmd, lmd_model);
      @(negedge clk); #1;
      check("fault_end", fault, 1'b0);
      return;
    end

    check("start_stall", stall, 1'b1);
    check("start_req0", mem_req, 1'b0);
    if (re) exp_q.push_back(model_load(f3, addr, rd));

    @(negedge clk); ex_valid = 1'b0; #1;
    check("req", mem_req, 1'b1);
    check("we", mem_we, we);
    check("addr", mem_addr, addr & ~32'd3);
    check("be", mem_be, exp_be);
    if (we) check("wdata", mem_wdata, exp_wd);

    done = 1'b0;
    k = 0;
    while (!done) begin
      if (k == waits) begin
        mem_ack = 1'b1; mem_rdata = rd; #1;
        check("ack_stall", stall, 1'b0);
        @(negedge clk); mem_ack = 1'b0; mem_rdata = $urandom; #1;
        check("req_drop", mem_req, 1'b0);
        if (re) lmd_model = exp_q.pop_front();
        check("lmd", lmd, lmd_model);
        done = 1'b1;
      end else begin
        mem_ack = 1'b0; mem_rdata = $urandom; #1;
        check("wait_stall", stall, 1'b1);
        check("wait_req", mem_req, 1'b1);
        if (k == TMO - 1) begin
          @(negedge clk); #1;
          check("tmo_bus_err", bus_err, 1'b1);
          check("tmo_req", mem_req, 1'b0);
          check("tmo_lmd", lmd, lmd_model);
          if (re) dummy = exp_q.pop_front();
          @(negedge clk); #1;
          check("bus_err_end", bus_err, 1'b0);
          done = 1'b1;
        end else begin
          @(negedge clk);
          k++;
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; ex_valid = 1'b0; ex_re = 1'b0; ex_we = 1'b0; ex_cond = 1'b0;
    ex_funct3 = '0; ex_addr = '0; ex_wdata = '0; ex_npc = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    lmd_model = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    #1;
    check("rst_req", mem_req, 1'b0);
    check("rst_lmd", lmd, 32'hFFFF_FFFF);
    check("rst_be", mem_be, 4'b0);
    check("rst_fault", fault, 1'b0);
    check("rst_bus_err", bus_err, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_state", dbg_state, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    // Directed cases
    do_access(1, 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF);   // LW 0 wait
    do_access(1, 0, 3'b000, 32'h103, 32'h0, 1, 32'h80AABBCC);   // LB
    do_access(1, 0, 3'b100, 32'h103, 32'h0, 0, 32'h80AABBCC);   // LBU
    do_access(0, 1, 3'b001, 32'h202, 32'h1234, 2, 32'h0);       // SH
    do_access(1, 0, 3'b001, 32'h101, 32'h0, 0, 32'h0);          // LH misaligned
    do_access(1, 0, 3'b010, 32'h104, 32'h0, 99, 32'h0);         // timeout
    do_access(1, 0, 3'b101, 32'h102, 32'h0, TMO - 1, 32'h9876_5432); // ack on last cycle
    do_access(1, 1, 3'b010, 32'h100, 32'h0, 0, 32'h0);          // both re and we
    do_access(1, 0, 3'b011, 32'h100, 32'h0, 0, 32'h0);          // LD on 32-bit
    do_access(0, 0, 3'b010, 32'h100, 32'h0, 0, 32'h0);          // pass-through

    // Reset in the middle of a 3-wait-state load
    @(negedge clk);
    ex_valid = 1'b1; ex_re = 1'b1; ex_we = 1'b0; ex_funct3 = 3'b010;
    ex_addr = 32'h300; ex_npc = 32'h404; ex_cond = 1'b0;
    #1;
    check("mid_start_stall", stall, 1'b1);
    @(negedge clk); ex_valid = 1'b0; mem_ack = 1'b0; #1;
    check("mid_req", mem_req, 1'b1);
    @(negedge clk); #1;
    ex_cond = 1'b1; #1;
    check("mid_condpc_t", condpc, 32'h300);
    rst_n = 1'b0; #1;
    check("mid_rst_req", mem_req, 1'b0);
    check("mid_rst_lmd", lmd, 32'hFFFF_FFFF);
    check("mid_rst_stall", stall, 1'b0);
    ex_cond = 1'b0; #1;
    check("mid_condpc_nt", condpc, 32'h404);
    lmd_model = 32'hFFFF_FFFF;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    check("post_rst_req", mem_req, 1'b0);

    // Randomized accesses
    for (int n = 0; n < 80; n++) begin
      int sel;
      bit re, we;
      sel = $urandom_range(0, 5);
      re = (sel == 1) || (sel == 2) || (sel == 3);
      we = (sel == 1) || (sel == 4) || (sel == 5);
      do_access(re, we, 3'($urandom_range(0, 7)), 32'h1000 + 32'($urandom_range(0, 15)),
                $urandom, $urandom_range(0, TMO + 1), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
